responder: RTL and testbench
============================

Name: responder

Overview:
- USB Type-C authentication responder; the counterpart of the authentication initiator.
- Captures one 1000-bit request from the initiator, decodes the header, and builds a DIGESTS, CERTIFICATE or ERROR response. It then returns that response over a four-phase read_req handshake.
- Certificate bytes come from an external synchronous certificate ROM; the slot-0 digest comes from an input port.

Parameters:
- CERT_LEN, 512: slot-0 certificate chain length in bytes.
- CERT_AW, 10: certificate ROM address width.
- MAX_PORTION, 117: maximum certificate bytes per response (125 message bytes minus 8 header bytes).
- SLOT_MASK, 8'h01: populated-slot bitmap reported in DIGESTS Param2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- read_req_in  in  1  request valid from initiator; held high until read_req_out is seen high.
- auth_msg_resp_in  in  1000  request message; byte k occupies bits [8k+7:8k].
- digest_in  in  256  slot-0 certificate chain digest; digest byte 0 is digest_in[7:0].
- cert_data  in  8  certificate ROM read data; valid one cycle after cert_addr.
- cert_addr  out  CERT_AW  certificate ROM byte address.
- read_req_out  out  1  response valid.
- auth_msg_resp_out  out  1000  response message, same byte layout as the request.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
  - Reset values: read_req_out=0, auth_msg_resp_out=0, cert_addr=0, busy=0, state=IDLE, req_prev=0.
  - A reset during any operation abandons it immediately.
  - A request held high across reset is serviced as a new request after reset release.
- Byte layout and field values:
  - Header: byte0 ProtocolVersion, byte1 MessageType, byte2 Param1, byte3 Param2.
  - Multi-byte fields are little-endian.
  - Response bytes that are not written are 0.
- Request capture and decode:
  - IDLE: on an edge where read_req_in=1 and req_prev=0, latch auth_msg_resp_in and go to DECODE. req_prev is read_req_in registered each cycle.
  - DECODE (1 cycle), first matching rule wins:
    - byte0 != 0x01 -> ERROR code 0x02 (UnsupportedProtocol).
    - byte1 = 0x81 (GET_DIGESTS) -> DIGEST.
    - byte1 = 0x82 (GET_CERTIFICATE): if Param1[3:0] != 0, or SLOT_MASK[0] = 0, or Offset (bytes 4-5) >= CERT_LEN -> ERROR 0x01 (InvalidRequest); otherwise -> CERT_FETCH.
    - Any other byte1, including 0x83 CHALLENGE -> ERROR 0x07 (UnsupportedRequest).
- Response formats:
  - ERROR: 0x01, 0x7F, Param1 = code, Param2 = 0x00.
  - DIGESTS: 0x01, 0x01, 0x00, SLOT_MASK, then bytes 4..35 = digest_in.
  - CERTIFICATE: 0x01, 0x02, Param1 = slot, 0x00, then bytes 4-5 PortionLength, bytes 6-7 RemainderLength, then bytes 8.. certificate data.
- CERT_FETCH arithmetic:
  - Portion = min(Length, MAX_PORTION, CERT_LEN-Offset), with Length taken from bytes 6-7.
  - Remainder = CERT_LEN-Offset-Portion.
  - Compute in 16 bits with no wrap: Offset is already checked < CERT_LEN.
  - Length=0 gives Portion=0 and a header-only response.
- CERT_FETCH sequencing:
  - cert_addr = Offset+i for i = 0..Portion-1, one address per cycle.
  - cert_data returned for address i is written to byte 8+i.
  - The state lasts Portion+1 cycles (ROM latency).
- Latency, counted from capture edge E:
  - DIGESTS and ERROR: read_req_out high after edge E+2.
  - CERTIFICATE: read_req_out high after edge E+3+Portion.
- RESPOND and release:
  - auth_msg_resp_out is stable while read_req_out=1.
  - The first cycle read_req_in=0 is sampled, read_req_out drops on that edge and the state returns to IDLE.
  - auth_msg_resp_out holds the last response until the next response is loaded.
- Abandon: if read_req_in drops during DECODE, DIGEST or CERT_FETCH, return to IDLE without asserting read_req_out and leave auth_msg_resp_out unchanged.
- read_req_in staying high after a response does not retrigger; a new request requires a 0->1 edge.

Test Plan:
- GET_DIGESTS, digest_in=0x00..1F ascending:
  - Response bytes 0-3 = 01 01 00 01, bytes 4..35 = 00..1F, rest 0.
  - read_req_out rises after E+2 and drops one edge after read_req_in falls.
- GET_CERTIFICATE, Offset=0, Length=0xFFFF, ROM[a]=a[7:0]:
  - PortionLength=117, RemainderLength=395, bytes 8..124 = 00..74.
  - read_req_out after E+120.
- GET_CERTIFICATE, Offset=500, Length=20: PortionLength=12, RemainderLength=0, data = F4..FF.
- Error cases:
  - Offset=512 -> 01 7F 01 00.
  - Version 0x02 -> 01 7F 02 00.
  - CHALLENGE 0x83 -> 01 7F 07 00.
  - Slot 1 -> 01 7F 01 00.
- Abandon: drop read_req_in at cycle E+5 of a 117-byte fetch -> read_req_out never rises, busy=0 by E+7, and a next request is serviced normally.
- Reset mid-fetch: assert reset asynchronously -> all outputs 0 immediately; with read_req_in still high at release, the request is re-captured and answered.

Source files
------------

// File: rtl/responder.sv
// USB Type-C authentication responder: captures one request, builds a
// DIGESTS / CERTIFICATE / ERROR response and returns it over a four-phase
// read_req handshake. Certificate bytes come from an external sync ROM.
module responder #(
  parameter int         CERT_LEN    = 512,
  parameter int         CERT_AW     = 10,
  parameter int         MAX_PORTION = 117,
  parameter logic [7:0] SLOT_MASK   = 8'h01
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               read_req_in,
  input  logic [999:0]       auth_msg_resp_in,
  input  logic [255:0]       digest_in,
  input  logic [7:0]         cert_data,
  output logic [CERT_AW-1:0] cert_addr,
  output logic               read_req_out,
  output logic [999:0]       auth_msg_resp_out,
  output logic               busy
);

  localparam logic [15:0] CERT_LEN16 = 16'(CERT_LEN);
  localparam logic [15:0] MAX_P16    = 16'(MAX_PORTION);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_FETCH, S_BUILD, S_RESPOND
  } state_t;

  typedef enum logic [1:0] {K_ERR, K_DIG, K_CERT} kind_t;

  state_t r_state, w_next;

  logic               r_req_prev;
  logic [7:0]         r_ver, r_type;
  logic [3:0]         r_slot;
  logic [15:0]        r_offset, r_length;
  logic [15:0]        r_portion, r_cnt;
  logic [CERT_AW-1:0] r_cert_addr;
  logic [999:0]       r_build, r_resp;

  kind_t       w_kind;
  logic [7:0]  w_code;
  logic [15:0] w_avail, w_portion, w_remain;
  logic [9:0]  w_bit_lo;
  logic        w_capture;
  logic        w_unused_bits;

  // Only the header and the offset/length fields are ever looked at.
  assign w_unused_bits = ^{auth_msg_resp_in[999:64], auth_msg_resp_in[31:20]};

  assign w_capture = read_req_in && !r_req_prev;
  // ROM data seen while r_cnt=c belongs to address Offset+c-1 -> byte 7+c.
  assign w_bit_lo  = 10'((r_cnt + 16'd7) << 3);

  assign cert_addr         = r_cert_addr;
  assign auth_msg_resp_out = r_resp;

  // Header decode: first matching rule decides the response kind.
  always_comb begin
    w_kind = K_ERR;
    w_code = 8'h07;
    if (r_ver != 8'h01) begin
      w_code = 8'h02;
    end else if (r_type == 8'h81) begin
      w_kind = K_DIG;
    end else if (r_type == 8'h82) begin
      if (r_slot != 4'h0 || !SLOT_MASK[0] || r_offset >= CERT_LEN16)
        w_code = 8'h01;
      else
        w_kind = K_CERT;
    end
  end

  // Portion = min(Length, MAX_PORTION, CERT_LEN-Offset); Offset < CERT_LEN
  // whenever this result is used, so nothing wraps.
  always_comb begin
    w_avail   = CERT_LEN16 - r_offset;
    w_portion = r_length;
    if (w_portion > MAX_P16) w_portion = MAX_P16;
    if (w_portion > w_avail) w_portion = w_avail;
    w_remain  = w_avail - w_portion;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and handshake outputs; a dropped request abandons any
  // in-flight work before the response is published.
  always_comb begin
    w_next       = r_state;
    read_req_out = 1'b0;
    busy         = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE:    if (w_capture) w_next = S_DECODE;
      S_DECODE:  if (!read_req_in)          w_next = S_IDLE;
                 else if (w_kind == K_CERT) w_next = S_FETCH;
                 else                       w_next = S_BUILD;
      S_FETCH:   if (!read_req_in)          w_next = S_IDLE;
                 else if (r_cnt == r_portion) w_next = S_BUILD;
      S_BUILD:   w_next = read_req_in ? S_RESPOND : S_IDLE;
      S_RESPOND: begin
        read_req_out = 1'b1;
        if (!read_req_in) w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath: request capture, response assembly, ROM streaming, publish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_prev  <= 1'b0;
      r_ver       <= '0;
      r_type      <= '0;
      r_slot      <= '0;
      r_offset    <= '0;
      r_length    <= '0;
      r_portion   <= '0;
      r_cnt       <= '0;
      r_cert_addr <= '0;
      r_build     <= '0;
      r_resp      <= '0;
    end else begin
      r_req_prev <= read_req_in;
      unique case (r_state)
        S_IDLE: if (w_capture) begin
          r_ver    <= auth_msg_resp_in[7:0];
          r_type   <= auth_msg_resp_in[15:8];
          r_slot   <= auth_msg_resp_in[19:16];
          r_offset <= auth_msg_resp_in[47:32];
          r_length <= auth_msg_resp_in[63:48];
        end
        S_DECODE: begin
          r_build     <= '0;
          r_cnt       <= '0;
          r_portion   <= w_portion;
          r_cert_addr <= r_offset[CERT_AW-1:0];
          unique case (w_kind)
            K_DIG:   r_build[287:0] <= {digest_in, SLOT_MASK, 8'h00, 8'h01, 8'h01};
            K_CERT:  r_build[63:0]  <= {w_remain, w_portion, 8'h00, {4'h0, r_slot},
                                        8'h02, 8'h01};
            default: r_build[31:0]  <= {8'h00, w_code, 8'h7F, 8'h01};
          endcase
        end
        S_FETCH: begin
          r_cnt       <= r_cnt + 16'd1;
          r_cert_addr <= r_cert_addr + CERT_AW'(1);
          if (r_cnt != 16'd0) r_build[w_bit_lo +: 8] <= cert_data;
        end
        S_BUILD: if (read_req_in) r_resp <= r_build;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_responder.sv
// Scoreboard bench for responder: stimulus pushes expected responses and
// latencies; a monitor pops and compares on each read_req_out rise.
module tb_responder;
  typedef logic [999:0] msg_t;
  typedef struct {
    msg_t resp;
    int   lat;
    int   cap;
  } exp_t;

  logic         clk, reset, read_req_in;
  msg_t         auth_msg_resp_in, auth_msg_resp_out;
  logic [255:0] digest_in;
  logic [7:0]   cert_data;
  logic [9:0]   cert_addr;
  logic         read_req_out, busy;

  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0;
  msg_t last_resp = '0;
  logic mon_prev = 1'b0;

  responder dut (
    .clk(clk), .reset(reset), .read_req_in(read_req_in),
    .auth_msg_resp_in(auth_msg_resp_in), .digest_in(digest_in),
    .cert_data(cert_data), .cert_addr(cert_addr), .read_req_out(read_req_out),
    .auth_msg_resp_out(auth_msg_resp_out), .busy(busy)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;
  // Certificate ROM: ROM[a] = a[7:0], one cycle read latency.
  always @(posedge clk) cert_data <= cert_addr[7:0];

  function automatic msg_t mk_req(logic [7:0] ver, logic [7:0] typ, logic [7:0] p1,
                                  logic [15:0] off, logic [15:0] len);
    msg_t m = '0;
    m[7:0] = ver; m[15:8] = typ; m[23:16] = p1; m[47:32] = off; m[63:48] = len;
    return m;
  endfunction

  function automatic msg_t err_resp(logic [7:0] code);
    msg_t m = '0;
    m[31:0] = {8'h00, code, 8'h7F, 8'h01};
    return m;
  endfunction

  function automatic msg_t dig_resp();
    msg_t m = '0;
    m[31:0] = 32'h0100_0101;
    for (int k = 0; k < 32; k++) m[8*(4+k) +: 8] = 8'(k);
    return m;
  endfunction

  function automatic msg_t cert_resp(int off, int portion, int rem);
    msg_t m = '0;
    m[15:0]  = 16'h0201;
    m[47:32] = 16'(portion);
    m[63:48] = 16'(rem);
    for (int i = 0; i < portion; i++) m[8*(8+i) +: 8] = 8'(off + i);
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic chk_msg(string name, msg_t got, msg_t exp);
    int d = -1;
    checks++;
    for (int k = 0; k < 125; k++)
      if (d < 0 && got[8*k +: 8] !== exp[8*k +: 8]) d = k;
    if (d >= 0) begin
      errors++;
      $display("FAIL %s byte %0d got %h exp %h", name, d, got[8*d +: 8], exp[8*d +: 8]);
    end
  endtask

  // Wait for the response, check it holds, then release the handshake.
  task automatic finish_resp(string name, msg_t exp, int lat);
    int n = 0;
    while (!read_req_out && n < lat + 10) begin @(negedge clk); n++; end
    if (!read_req_out) begin
      checks++; errors++;
      $display("FAIL %s_timeout got no read_req_out after %0d cycles", name, n);
    end
    repeat (2) @(negedge clk);
    chk({name, "_hold_vld"}, 32'(read_req_out), 32'd1);
    chk_msg({name, "_hold"}, auth_msg_resp_out, exp);
    read_req_in = 1'b0;
    @(negedge clk);
    chk({name, "_drop"}, {30'd0, read_req_out, busy}, 32'd0);
    last_resp = exp;
  endtask

  task automatic send(string name, msg_t req, msg_t exp, int lat);
    @(negedge clk);
    auth_msg_resp_in = req;
    read_req_in      = 1'b1;
    sb.push_back('{resp: exp, lat: lat, cap: cyc + 1});
    finish_resp(name, exp, lat);
  endtask

  // Monitor: compare content and latency at every read_req_out rise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (read_req_out && !mon_prev) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp got read_req_out=1 exp 0");
        end else begin
          e = sb.pop_front();
          chk_msg("resp", auth_msg_resp_out, e.resp);
          chk("latency", 32'(cyc - e.cap), 32'(e.lat));
        end
      end
      mon_prev = read_req_out;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    reset = 1'b1; read_req_in = 1'b0; auth_msg_resp_in = '0;
    for (int k = 0; k < 32; k++) digest_in[8*k +: 8] = 8'(k);
    repeat (3) @(negedge clk);
    chk("rst_ctl", {30'd0, read_req_out, busy}, 32'd0);
    chk("rst_addr", 32'(cert_addr), 32'd0);
    chk_msg("rst_resp", auth_msg_resp_out, '0);
    reset = 1'b0;

    send("digests", mk_req(8'h01, 8'h81, 8'h00, 16'd0, 16'd0), dig_resp(), 2);
    send("cert_full", mk_req(8'h01, 8'h82, 8'h00, 16'd0, 16'hFFFF),
         cert_resp(0, 117, 395), 120);
    send("cert_tail", mk_req(8'h01, 8'h82, 8'h00, 16'd500, 16'd20),
         cert_resp(500, 12, 0), 15);
    send("cert_len0", mk_req(8'h01, 8'h82, 8'h00, 16'd0, 16'd0),
         cert_resp(0, 0, 512), 3);
    send("err_offset", mk_req(8'h01, 8'h82, 8'h00, 16'd512, 16'd4), err_resp(8'h01), 2);
    send("err_version", mk_req(8'h02, 8'h81, 8'h00, 16'd0, 16'd0), err_resp(8'h02), 2);
    send("err_challenge", mk_req(8'h01, 8'h83, 8'h00, 16'd0, 16'd0), err_resp(8'h07), 2);
    send("err_slot", mk_req(8'h01, 8'h82, 8'h01, 16'd0, 16'd16), err_resp(8'h01), 2);

    // Abandon a long fetch by dropping the request at E+5.
    @(negedge clk);
    auth_msg_resp_in = mk_req(8'h01, 8'h82, 8'h00, 16'd0, 16'hFFFF);
    read_req_in = 1'b1;
    e0 = cyc + 1;
    while (cyc < e0 + 4) @(negedge clk);
    read_req_in = 1'b0;
    while (cyc < e0 + 6) @(negedge clk);
    chk("abandon_ctl", {30'd0, read_req_out, busy}, 32'd0);
    chk_msg("abandon_resp", auth_msg_resp_out, last_resp);
    repeat (3) @(negedge clk);
    send("after_abandon", mk_req(8'h01, 8'h81, 8'h00, 16'd0, 16'd0), dig_resp(), 2);

    // Asynchronous reset mid-fetch; the held request is re-captured after release.
    @(negedge clk);
    auth_msg_resp_in = mk_req(8'h01, 8'h82, 8'h00, 16'd0, 16'hFFFF);
    read_req_in = 1'b1;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ctl", {30'd0, read_req_out, busy}, 32'd0);
    chk("midrst_addr", 32'(cert_addr), 32'd0);
    chk_msg("midrst_resp", auth_msg_resp_out, '0);
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{resp: cert_resp(0, 117, 395), lat: 120, cap: cyc + 1});
    finish_resp("recapture", cert_resp(0, 117, 395), 120);

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
